// File: rtl/keypad_entry.sv
// keypad_entry: debounces the one-hot keypad, encodes each accepted key to BCD
// and shifts it into a three-digit time register (mins, sec_tens, sec_ones).
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       digit_valid,
  output logic [1:0] digits_entered,
  output logic       time_nonzero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

  state_t     state_q, state_d;
  logic [9:0] pat_q, pat_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mins_q, mins_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       valid_q, valid_d;
  logic [1:0] entered_q, entered_d;

  logic       onehot;
  logic [3:0] code;
  logic       accept;
  logic [3:0] cnt_inc;

  // Key classification: exactly one bit set is a valid key, encoded to its index.
  always_comb begin
    onehot = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    code   = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (keypad[i]) code = 4'(i);
    end
  end

  assign cnt_inc = cnt_q + 4'd1;

  // Debounce FSM plus the digit shift register; clear overrides any accept.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    mins_d    = mins_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    entered_d = entered_q;
    valid_d   = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && onehot) begin
          pat_d = keypad;
          if (DEBOUNCE_CYCLES == 1) begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d   = 4'd1;
            state_d = PRESS;
          end
        end
      end
      PRESS: begin
        if (!enable || keypad != pat_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_inc == DEB) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (keypad != '0) begin
          cnt_d = '0;
        end else if (cnt_inc == DEB) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      mins_d    = '0;
      tens_d    = '0;
      ones_d    = '0;
      entered_d = '0;
      cnt_d     = '0;
      state_d   = HOLD;
    end else if (accept) begin
      mins_d  = tens_q;
      tens_d  = ones_q;
      ones_d  = code;
      valid_d = 1'b1;
      if (entered_q != 2'd3) entered_d = entered_q + 2'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      cnt_q     <= '0;
      mins_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      valid_q   <= 1'b0;
      entered_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      mins_q    <= mins_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      valid_q   <= valid_d;
      entered_q <= entered_d;
    end
  end

  assign mins           = mins_q;
  assign sec_tens       = tens_q;
  assign sec_ones       = ones_q;
  assign digit_valid    = valid_q;
  assign digits_entered = entered_q;
  assign time_nonzero   = |{mins_q, tens_q, ones_q};

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: scoreboard of expected digit-register snapshots,
// popped on every digit_valid pulse, plus per-scenario steady-state checks.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keypad;
  logic       enable;
  logic       clear;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       digit_valid;
  logic [1:0] digits_entered;
  logic       time_nonzero;

  keypad_entry #(.DEBOUNCE_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .keypad         (keypad),
    .enable         (enable),
    .clear          (clear),
    .mins           (mins),
    .sec_tens       (sec_tens),
    .sec_ones       (sec_ones),
    .digit_valid    (digit_valid),
    .digits_entered (digits_entered),
    .time_nonzero   (time_nonzero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Expected register model and scoreboard of {mins, tens, ones, entered}.
  logic [3:0]  m_mins = 0, m_tens = 0, m_ones = 0;
  logic [1:0]  m_ent = 0;
  logic [13:0] exp_q[$];

  task automatic model_zero();
    m_mins = 0; m_tens = 0; m_ones = 0; m_ent = 0;
  endtask

  task automatic push_digit(input int d);
    m_mins = m_tens;
    m_tens = m_ones;
    m_ones = 4'(d);
    if (m_ent != 2'd3) m_ent = m_ent + 2'd1;
    exp_q.push_back({m_mins, m_tens, m_ones, m_ent});
  endtask

  // Scoreboard monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (digit_valid === 1'b1) begin
      logic [13:0] got;
      logic [13:0] e;
      n_pulse++;
      n_cmp++;
      got = {mins, sec_tens, sec_ones, digits_entered};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pulse_unexpected: got regs %h, required no pulse", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL pulse_regs: got %h, required %h", got, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int hold, input int gap, input bit acc);
    if (acc) push_digit(k);
    keypad = '0;
    keypad[k] = 1'b1;
    cyc(hold);
    keypad = '0;
    cyc(gap);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_zero();
    cyc(1);
    clear = 1'b0;
    cyc(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; keypad = '0; enable = 1'b1; clear = 1'b0;
    cyc(3);
    n_cmp++; if (mins !== 4'd0) begin n_err++; $display("FAIL reset_mins: got %0d, required 0", mins); end
    n_cmp++; if (sec_tens !== 4'd0) begin n_err++; $display("FAIL reset_tens: got %0d, required 0", sec_tens); end
    n_cmp++; if (sec_ones !== 4'd0) begin n_err++; $display("FAIL reset_ones: got %0d, required 0", sec_ones); end
    n_cmp++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", digit_valid); end
    n_cmp++; if (digits_entered !== 2'd0) begin n_err++; $display("FAIL reset_entered: got %0d, required 0", digits_entered); end
    n_cmp++; if (time_nonzero !== 1'b0) begin n_err++; $display("FAIL reset_nonzero: got %b, required 0", time_nonzero); end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_basic_entry();
    int p0 = n_pulse;
    press(3, 11, 11, 1'b1);
    press(5, 11, 11, 1'b1);
    press(9, 11, 11, 1'b1);
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h359) begin n_err++; $display("FAIL basic_digits: got %h, required 359", {mins, sec_tens, sec_ones}); end
    n_cmp++; if (n_pulse - p0 !== 3) begin n_err++; $display("FAIL basic_pulses: got %0d, required 3", n_pulse - p0); end
    n_cmp++; if (digits_entered !== 2'd3) begin n_err++; $display("FAIL basic_entered: got %0d, required 3", digits_entered); end
    n_cmp++; if (time_nonzero !== 1'b1) begin n_err++; $display("FAIL basic_nonzero: got %b, required 1", time_nonzero); end
  endtask

  task automatic test_no_clamp_shift();
    do_clear();
    n_cmp++; if (time_nonzero !== 1'b0) begin n_err++; $display("FAIL clamp_cleared_nonzero: got %b, required 0", time_nonzero); end
    press(1, 4, 4, 1'b1);
    press(7, 4, 4, 1'b1);
    press(9, 4, 4, 1'b1);
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h179) begin n_err++; $display("FAIL clamp_179: got %h, required 179", {mins, sec_tens, sec_ones}); end
    press(4, 4, 4, 1'b1);
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h794) begin n_err++; $display("FAIL shift_794: got %h, required 794", {mins, sec_tens, sec_ones}); end
    n_cmp++; if (digits_entered !== 2'd3) begin n_err++; $display("FAIL shift_entered: got %0d, required 3", digits_entered); end
  endtask

  task automatic test_glitch();
    int p0 = n_pulse;
    press(5, 1, 4, 1'b0);
    keypad = 10'b0000000100; cyc(1);
    keypad = 10'b0000001000; cyc(1);
    keypad = '0;             cyc(4);
    keypad = 10'b0000001100; cyc(10);
    keypad = '0;             cyc(4);
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d, required 0", n_pulse - p0); end
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h794) begin n_err++; $display("FAIL glitch_digits: got %h, required 794", {mins, sec_tens, sec_ones}); end
  endtask

  task automatic test_hold_release();
    int p0 = n_pulse;
    press(2, 50, 1, 1'b1);
    press(2, 5, 5, 1'b0);
    n_cmp++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL hold_single_pulse: got %0d, required 1", n_pulse - p0); end
    press(2, 5, 5, 1'b1);
    n_cmp++; if (n_pulse - p0 !== 2) begin n_err++; $display("FAIL hold_second_pulse: got %0d, required 2", n_pulse - p0); end
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h422) begin n_err++; $display("FAIL hold_digits: got %h, required 422", {mins, sec_tens, sec_ones}); end
  endtask

  task automatic test_clear_held();
    int p0;
    do_clear();
    press(2, 4, 4, 1'b1);
    press(4, 4, 4, 1'b1);
    press(5, 4, 4, 1'b1);
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h245) begin n_err++; $display("FAIL clear_pre_245: got %h, required 245", {mins, sec_tens, sec_ones}); end
    p0 = n_pulse;
    keypad = 10'b0001000000;
    clear = 1'b1;
    model_zero();
    cyc(1);
    clear = 1'b0;
    cyc(10);
    n_cmp++; if ({mins, sec_tens, sec_ones} !== 12'h000) begin n_err++; $display("FAIL clear_digits: got %h, required 000", {mins, sec_tens, sec_ones}); end
    n_cmp++; if (digits_entered !== 2'd0) begin n_err++; $display("FAIL clear_entered: got %0d, required 0", digits_entered); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL clear_held_pulse: got %0d, required 0", n_pulse - p0); end
    keypad = '0;
    cyc(5);
    press(6, 4, 4, 1'b1);
    n_cmp++; if ({sec_ones, digits_entered} !== {4'd6, 2'd1}) begin n_err++; $display("FAIL clear_repress: got %h, required 61", {sec_ones, digits_entered}); end
  endtask

  task automatic test_enable_and_reset();
    int p0 = n_pulse;
    enable = 1'b0;
    keypad = 10'b0100000000;
    cyc(5);
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL enable_low_pulse: got %0d, required 0", n_pulse - p0); end
    push_digit(8);
    enable = 1'b1;
    cyc(5);
    keypad = '0;
    cyc(5);
    n_cmp++; if ({mins, sec_tens, sec_ones, digits_entered} !== {4'd0, 4'd6, 4'd8, 2'd2}) begin
      n_err++; $display("FAIL enable_accept: got %h, required %h", {mins, sec_tens, sec_ones, digits_entered}, {4'd0, 4'd6, 4'd8, 2'd2});
    end
    keypad = 10'b0000000010;
    cyc(1);
    rst = 1'b1;
    model_zero();
    cyc(1);
    n_cmp++; if ({mins, sec_tens, sec_ones, digits_entered, digit_valid, time_nonzero} !== 16'h0) begin
      n_err++; $display("FAIL rst_mid_press: got %h, required 0000", {mins, sec_tens, sec_ones, digits_entered, digit_valid, time_nonzero});
    end
    rst = 1'b0;
    keypad = '0;
    cyc(5);
    n_cmp++; if (sec_ones !== 4'd0) begin n_err++; $display("FAIL rst_key_dropped: got %0d, required 0", sec_ones); end
  endtask

  initial begin
    rst = 1'b1; keypad = '0; enable = 1'b1; clear = 1'b0;
    test_reset();
    test_basic_entry();
    test_no_clamp_shift();
    test_glitch();
    test_hold_release();
    test_clear_held();
    test_enable_and_reset();
    cyc(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_pulses: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
